// File: rtl/mio_bus_responder_if.sv
// CPU-side MIO bus between the SCPU load/store unit and the responder.
// Handshake: master holds mem_req (with mem_w/Addr_out/Data_out) until it sees
// MIO_ready; the slave pulses MIO_ready for exactly one cycle to complete the access.
interface mio_bus_responder_if;
  logic        mem_req;
  logic        mem_w;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        bus_err;

  modport master (
    output mem_req, mem_w, Addr_out, Data_out,
    input  Data_in, MIO_ready, bus_err
  );

  modport slave (
    input  mem_req, mem_w, Addr_out, Data_out,
    output Data_in, MIO_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_responder.sv
// MIO bus responder: word RAM, GPIO output register and switch port behind
// a per-region wait-state FSM (IDLE -> WAIT -> ACK).
module mio_bus_responder #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 2,
  parameter int IO_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mio_bus_responder_if.slave    bus,
  output logic [31:0]           gpio_out,
  input  logic [31:0]           sw_in,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;
  typedef enum logic [1:0] {R_RAM = 2'd0, R_GPIO = 2'd1, R_SW = 2'd2, R_NONE = 2'd3} region_t;

  localparam logic [29:0] GPIO_WADDR = 30'h3C00_0000;
  localparam logic [29:0] SW_WADDR   = 30'h3C00_0001;
  localparam logic [3:0]  RAM_WAIT_C = 4'(RAM_WAIT);
  localparam logic [3:0]  IO_WAIT_C  = 4'(IO_WAIT);

  state_t              state;
  logic [3:0]          cnt;
  region_t             lat_region;
  logic [RAM_AW-1:0]   lat_idx;
  logic                lat_w;
  logic [31:0]         lat_data;

  region_t             live_region;
  logic [3:0]          live_wait;
  region_t             cur_region;
  logic [RAM_AW-1:0]   cur_idx;
  logic                cur_w;
  logic [31:0]         cur_data;
  logic [31:0]         rd_data;
  logic                enter_ack;
  logic                unused_addr_bits;

  logic [31:0] ram [0:(1<<RAM_AW)-1];

  assign unused_addr_bits = ^bus.Addr_out[1:0];
  assign dbg_state = state;

  always_comb begin
    live_region = R_NONE;
    if (bus.Addr_out[31:RAM_AW+2] == '0)       live_region = R_RAM;
    else if (bus.Addr_out[31:2] == GPIO_WADDR) live_region = R_GPIO;
    else if (bus.Addr_out[31:2] == SW_WADDR)   live_region = R_SW;
    live_wait = (live_region == R_RAM) ? RAM_WAIT_C : IO_WAIT_C;
  end

  // A zero-wait access goes IDLE -> ACK directly, so it must act on the live
  // bus values rather than the copies latched on that same edge.
  always_comb begin
    if (state == S_IDLE) begin
      cur_region = live_region;
      cur_idx    = bus.Addr_out[RAM_AW+1:2];
      cur_w      = bus.mem_w;
      cur_data   = bus.Data_out;
    end else begin
      cur_region = lat_region;
      cur_idx    = lat_idx;
      cur_w      = lat_w;
      cur_data   = lat_data;
    end
    unique case (cur_region)
      R_RAM:   rd_data = ram[cur_idx];
      R_GPIO:  rd_data = gpio_out;
      R_SW:    rd_data = sw_in;
      default: rd_data = '0;
    endcase
  end

  assign enter_ack = rst_n && bus.mem_req &&
                     (((state == S_IDLE) && (live_wait == 4'd0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1)));

  // RAM has no reset; the rst_n term in enter_ack blocks writes during reset.
  always_ff @(posedge clk) begin
    if (enter_ack && cur_w && (cur_region == R_RAM))
      ram[cur_idx] <= cur_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_region    <= R_NONE;
      lat_idx       <= '0;
      lat_w         <= 1'b0;
      lat_data      <= '0;
      bus.MIO_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.Data_in   <= '0;
      gpio_out      <= '0;
    end else begin
      bus.MIO_ready <= enter_ack;
      bus.bus_err   <= enter_ack && (cur_region == R_NONE);
      bus.Data_in   <= (enter_ack && !cur_w) ? rd_data : '0;
      if (enter_ack && cur_w && (cur_region == R_GPIO))
        gpio_out <= cur_data;

      unique case (state)
        S_IDLE: begin
          if (bus.mem_req) begin
            lat_region <= live_region;
            lat_idx    <= bus.Addr_out[RAM_AW+1:2];
            lat_w      <= bus.mem_w;
            lat_data   <= bus.Data_out;
            cnt        <= live_wait;
            state      <= (live_wait == 4'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.mem_req) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed vector table, corner
// sequences (abort, reset mid-access, back-to-back) and randomized accesses.
module tb_mio_bus_responder;
  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 2;
  localparam int IO_WAIT  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sw_in;
  logic [31:0] gpio_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mio_bus_responder_if bus();

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .gpio_out(gpio_out), .sw_in(sw_in), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] sw;
    logic [31:0] exp_din;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] ram_m [int];
  logic [31:0] gpio_m;
  int          exp_ram_lat = RAM_WAIT + 1;
  int          exp_io_lat  = IO_WAIT + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits for MIO_ready; outputs must read 0 in every non-ready cycle.
  task automatic wait_ready(input logic scramble, output int n, output logic ok);
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.MIO_ready) begin
        ok = 1'b1;
        break;
      end
      check("din_zero_wait", bus.Data_in, 32'h0);
      check("err_zero_wait", {31'b0, bus.bus_err}, 32'h0);
      if (scramble && n == 1) begin
        bus.Addr_out = $urandom;
        bus.Data_out = $urandom;
        bus.mem_w    = 1'($urandom);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: no MIO_ready after %0d cycles, required within 20", n);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] sw, output logic [31:0] din, output logic err,
                        output logic [31:0] gpio_ack, output int lat);
    logic ok;
    bus.mem_req  = 1'b1;
    bus.mem_w    = w;
    bus.Addr_out = addr;
    bus.Data_out = data;
    sw_in        = sw;
    wait_ready(1'b1, lat, ok);
    din      = bus.Data_in;
    err      = bus.bus_err;
    gpio_ack = gpio_out;
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'b0, bus.MIO_ready}, 32'h0);
    check("din_zero_after", bus.Data_in, 32'h0);
  endtask

  initial begin
    logic [31:0] din, gk, addr, data, sw, exp_din;
    logic        err, ok, w;
    int          lat, idx, r;
    bit          is_ram;

    bus.mem_req = 1'b0; bus.mem_w = 1'b0; bus.Addr_out = '0; bus.Data_out = '0;
    sw_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.MIO_ready}, 32'h0);
    check("rst_err",   {31'b0, bus.bus_err},   32'h0);
    check("rst_din",   bus.Data_in,            32'h0);
    check("rst_gpio",  gpio_out,               32'h0);
    rst_n = 1'b1;

    //                w     addr           data           sw             exp_din        err   lat  exp_gpio
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,         32'h0,         1'b0, 3, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'h1234_5678, 1'b0, 3, 32'h0};
    vecs[2]  = '{1'b1, 32'hF000_0000, 32'h0000_00FF, 32'h0,         32'h0,         1'b0, 2, 32'hFF};
    vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0,         32'h0,         32'h0000_00FF, 1'b0, 2, 32'hFF};
    vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 2, 32'hFF};
    vecs[5]  = '{1'b1, 32'hF000_0004, 32'h0000_DEAD, 32'h0,         32'h0,         1'b0, 2, 32'hFF};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         32'h0,         1'b1, 2, 32'hFF};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0000_0777, 32'h0,         32'h0,         1'b1, 2, 32'hFF};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'h1234_5678, 1'b0, 3, 32'hFF};
    vecs[9]  = '{1'b0, 32'hF000_0003, 32'h0,         32'h0,         32'h0000_00FF, 1'b0, 2, 32'hFF};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_BABE, 32'h0,         32'h0,         1'b0, 3, 32'hFF};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0,         32'hCAFE_BABE, 1'b0, 3, 32'hFF};
    vecs[12] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         32'h0,         1'b1, 2, 32'hFF};
    vecs[13] = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,         32'h1234_5678, 1'b0, 3, 32'hFF};

    for (int i = 0; i < 14; i++) begin
      access(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].sw, din, err, gk, lat);
      check($sformatf("vec%0d_lat", i),  lat,             vecs[i].exp_lat);
      check($sformatf("vec%0d_din", i),  din,             vecs[i].exp_din);
      check($sformatf("vec%0d_err", i),  {31'b0, err},    {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_gpio", i), gk,              vecs[i].exp_gpio);
    end

    // Abort after one WAIT cycle, then abort at the last WAIT cycle.
    access(1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, din, err, gk, lat);
    check("abort_pre_lat", lat, exp_ram_lat);
    for (int k = 1; k <= 2; k++) begin
      bus.mem_req = 1'b1; bus.mem_w = 1'b1;
      bus.Addr_out = 32'h0000_0020; bus.Data_out = 32'h2222_0000 + k;
      repeat (k) begin @(posedge clk); #1; end
      bus.mem_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        check($sformatf("abort%0d_no_ready", k), {31'b0, bus.MIO_ready}, 32'h0);
      end
    end
    access(1'b0, 32'h0000_0020, 32'h0, 32'h0, din, err, gk, lat);
    check("abort_old_value", din, 32'h1111_1111);

    // Reset asserted during WAIT of a GPIO store.
    bus.mem_req = 1'b1; bus.mem_w = 1'b1;
    bus.Addr_out = 32'hF000_0000; bus.Data_out = 32'h0000_0055;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    check("rst_mid_gpio", gpio_out, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_mid_no_ready", {31'b0, bus.MIO_ready}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_gpio_held", gpio_out, 32'h0);
    access(1'b1, 32'hF000_0000, 32'h0000_0033, 32'h0, din, err, gk, lat);
    check("post_rst_lat", lat, exp_io_lat);
    check("post_rst_gpio", gk, 32'h33);
    access(1'b0, 32'h0000_0010, 32'h0, 32'h0, din, err, gk, lat);
    check("post_rst_ram_kept", din, 32'h1234_5678);

    // Back-to-back: request stays high through ACK, next access after one IDLE cycle.
    bus.mem_req = 1'b1; bus.mem_w = 1'b0; bus.Addr_out = 32'h0000_0010;
    wait_ready(1'b0, lat, ok);
    check("b2b_first_din", bus.Data_in, 32'h1234_5678);
    bus.Addr_out = 32'hF000_0000;
    @(posedge clk); #1;
    check("b2b_idle_gap", {31'b0, bus.MIO_ready}, 32'h0);
    wait_ready(1'b1, lat, ok);
    check("b2b_second_lat", lat, exp_io_lat);
    check("b2b_second_din", bus.Data_in, 32'h33);
    bus.mem_req = 1'b0;
    @(posedge clk); #1;

    // Randomized accesses against the reference model.
    gpio_m = 32'h33;
    for (int t = 0; t < 120; t++) begin
      r    = $urandom_range(0, 3);
      w    = 1'($urandom);
      data = $urandom;
      sw   = $urandom;
      idx  = 0;
      is_ram = 1'b0;
      case (r)
        0: begin idx = $urandom_range(16, 31); addr = idx * 4 + $urandom_range(0, 3); is_ram = 1'b1; end
        1: addr = 32'hF000_0000 + $urandom_range(0, 3);
        2: addr = 32'hF000_0004 + $urandom_range(0, 3);
        default: addr = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 + $urandom_range(0, 32'hFFFF)
                                                     : 32'hF000_0008 + $urandom_range(0, 255);
      endcase
      access(w, addr, data, sw, din, err, gk, lat);
      check($sformatf("rnd%0d_lat", t), lat, is_ram ? exp_ram_lat : exp_io_lat);
      check($sformatf("rnd%0d_err", t), {31'b0, err}, (r == 3) ? 32'h1 : 32'h0);
      if (w) begin
        check($sformatf("rnd%0d_store_din", t), din, 32'h0);
        if (r == 0) ram_m[idx] = data;
        if (r == 1) gpio_m = data;
      end else begin
        exp_din = 32'h0;
        if (r == 1) exp_din = gpio_m;
        if (r == 2) exp_din = sw;
        if (r != 0 || ram_m.exists(idx)) begin
          if (r == 0) exp_din = ram_m[idx];
          check($sformatf("rnd%0d_load_din", t), din, exp_din);
        end
      end
      check($sformatf("rnd%0d_gpio", t), gk, gpio_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
